// File: rtl/fp8_outer_mul_pipe.sv
// fp8_outer_mul_pipe: 3-stage FP8 (E4M3/E5M2) outer-product multiplier producing exact FP16 products
//   clk, rst (async, active-low)
//   in_valid/in_ready, e5m2mode, in_tag, x[ROWS], y[COLS] : input beat
//   out_valid/out_ready, out_tag, p[ROWS*COLS], p_exc     : result beat, p[(r*COLS+c)] = x[r]*y[c]
module fp8_outer_mul_pipe #(
  parameter int ROWS  = 2,
  parameter int COLS  = 3,
  parameter int TAG_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    e5m2mode,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic [ROWS*8-1:0]       x,
  input  logic [COLS*8-1:0]       y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TAG_W-1:0]        out_tag,
  output logic [ROWS*COLS*16-1:0] p,
  output logic [ROWS*COLS-1:0]    p_exc
);
  localparam int N = ROWS + COLS;
  localparam int M = ROWS * COLS;
  typedef enum logic [1:0] {ZER, NRM, INF, NAN} cls_t;
  logic en;
  assign en = !(out_valid && !out_ready);
  assign in_ready = en;
  logic [N*8-1:0] ops;
  logic [N-1:0] s0, s1;
  logic [5:0] e0 [N];
  logic [5:0] e1 [N];
  logic [3:0] m0 [N];
  logic [3:0] m1 [N];
  cls_t c0 [N];
  cls_t c1 [N];
  logic v1, v2;
  logic [TAG_W-1:0] t1, t2;
  // operand i < ROWS is x[i], the rest are y[i-ROWS]
  assign ops = {y, x};
  // E5M2 mantissa is padded to 3 bits so both formats share one 4x4 multiplier
  for (genvar i = 0; i < N; i++) begin : g_unp
    logic [7:0] b;
    logic [4:0] ex;
    logic [2:0] mt;
    assign b = ops[i*8 +: 8];
    assign ex = e5m2mode ? b[6:2] : {1'b0, b[6:3]};
    assign mt = e5m2mode ? {b[1:0], 1'b0} : b[2:0];
    assign s0[i] = b[7];
    assign e0[i] = {1'b0, ex} - (e5m2mode ? 6'd15 : 6'd7);
    assign m0[i] = {1'b1, mt};
    assign c0[i] = ex == 5'd0 ? ZER
                 : e5m2mode ? (ex == 5'd31 ? (mt == 3'd0 ? INF : NAN) : NRM)
                 : (ex == 5'd15 && mt == 3'd7 ? NAN : NRM);
  end
  logic [M-1:0] s2n, s2;
  logic [6:0] e2n [M];
  logic [6:0] e2 [M];
  logic [7:0] m2n [M];
  logic [7:0] m2 [M];
  cls_t c2n [M];
  cls_t c2 [M];
  for (genvar k = 0; k < M; k++) begin : g_mul
    localparam int A = k / COLS;
    localparam int B = ROWS + k % COLS;
    assign s2n[k] = s1[A] ^ s1[B];
    assign e2n[k] = {e1[A][5], e1[A]} + {e1[B][5], e1[B]};
    assign m2n[k] = {4'd0, m1[A]} * {4'd0, m1[B]};
    assign c2n[k] = (c1[A] == NAN || c1[B] == NAN || (c1[A] == INF && c1[B] == ZER) || (c1[A] == ZER && c1[B] == INF)) ? NAN
                  : (c1[A] == INF || c1[B] == INF) ? INF
                  : (c1[A] == ZER || c1[B] == ZER) ? ZER : NRM;
  end
  logic [M*16-1:0] pn;
  logic [M-1:0] xn;
  // product is in [1.0, 4.0) scaled by 2^6; bit 7 set means >= 2.0
  for (genvar k = 0; k < M; k++) begin : g_pack
    logic signed [7:0] ee;
    logic [6:0] fr;
    logic [4:0] be;
    logic ov, un;
    assign ee = $signed({e2[k][6], e2[k]}) + $signed({7'd0, m2[k][7]});
    assign fr = m2[k][7] ? m2[k][6:0] : {m2[k][5:0], 1'b0};
    assign be = ee[4:0] + 5'd15;
    assign ov = ee > 8'sd15;
    assign un = ee < -8'sd14;
    assign pn[k*16 +: 16] = c2[k] == NAN ? 16'h7E00
                          : c2[k] == INF ? {s2[k], 15'h7C00}
                          : c2[k] == ZER ? {s2[k], 15'h0000}
                          : ov ? {s2[k], 15'h7BFF}
                          : un ? {s2[k], 15'h0000}
                          : {s2[k], be, fr, 3'b000};
    assign xn[k] = c2[k] == NAN || (c2[k] == NRM && (ov || un));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      out_tag <= '0;
      p <= '0;
      p_exc <= '0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
      out_valid <= v2;
      out_tag <= t2;
      p <= pn;
      p_exc <= xn;
    end
  always_ff @(posedge clk)
    if (en) begin
      t1 <= in_tag;
      s1 <= s0;
      e1 <= e0;
      m1 <= m0;
      c1 <= c0;
      t2 <= t1;
      s2 <= s2n;
      e2 <= e2n;
      m2 <= m2n;
      c2 <= c2n;
    end
endmodule

// File: tb/tb_fp8_outer_mul_pipe.sv
// tb_fp8_outer_mul_pipe: directed self-checking bench for fp8_outer_mul_pipe (ROWS=2, COLS=3)
module tb_fp8_outer_mul_pipe;
  logic clk = 0, rst = 0, in_valid = 0, e5m2mode = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [31:0] in_tag = 0, out_tag;
  logic [15:0] x = 0;
  logic [23:0] y = 0;
  logic [95:0] p;
  logic [5:0] p_exc;
  typedef struct {logic [31:0] tag; logic [95:0] p; logic [5:0] exc; int cyc;} res_t;
  res_t rq[$];
  int cyc = 0, n_acc = 0, n_tests = 0, n_fail = 0;
  localparam logic [15:0] XA = 16'h4C38, XB = 16'h423C;
  localparam logic [23:0] YA = 24'hC840C4, YB = 24'h3EBC40;
  localparam logic [95:0] PA = 96'hCE00_4A00_CC80_C400_4000_C200;
  localparam logic [95:0] PB = 96'h4480_C200_4600_3E00_BC00_4000;
  // {mode, a, b, expected p, expected exc}
  localparam logic [33:0] SAT [4] = '{
    {1'b0, 8'h7E, 8'h7E, 16'h7BFF, 1'b1},
    {1'b0, 8'hFE, 8'h7E, 16'hFBFF, 1'b1},
    {1'b1, 8'h04, 8'h04, 16'h0000, 1'b1},
    {1'b0, 8'h08, 8'h08, 16'h0C00, 1'b0}};
  localparam logic [33:0] SPC [5] = '{
    {1'b0, 8'h7F, 8'h38, 16'h7E00, 1'b1},
    {1'b1, 8'h7C, 8'hC0, 16'hFC00, 1'b0},
    {1'b1, 8'h7C, 8'h00, 16'h7E00, 1'b1},
    {1'b0, 8'h80, 8'h38, 16'h8000, 1'b0},
    {1'b0, 8'h01, 8'h38, 16'h0000, 1'b0}};

  fp8_outer_mul_pipe #(.ROWS(2), .COLS(3), .TAG_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .e5m2mode(e5m2mode),
    .in_tag(in_tag), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .p(p), .p_exc(p_exc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) rq.push_back('{out_tag, p, p_exc, cyc});
    if (rst && in_valid && in_ready) n_acc <= n_acc + 1;
  end

  task automatic drive(input logic m, input logic [31:0] t, input logic [15:0] xv, input logic [23:0] yv);
    logic r;
    int k;
    e5m2mode = m; in_tag = t; x = xv; y = yv; in_valid = 1;
    r = 0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) break;
    end
    if (k == 50) begin n_tests++; n_fail++; $display("FAIL drive_timeout tag=%0d accepted=0 want 1", t); end
  endtask

  task automatic wait_res(input int n);
    int k = 0;
    while (rq.size() < n && k < 40) begin @(posedge clk); #1; k++; end
  endtask

  task automatic test_reset();
    rst = 0; out_ready = 1;
    repeat (3) @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (p !== '0) begin n_fail++; $display("FAIL reset_p got %h want 0", p); end
    n_tests++; if ({out_tag, p_exc} !== '0) begin n_fail++; $display("FAIL reset_tag_exc got %h/%b want 0/0", out_tag, p_exc); end
    rst = 1;
    @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int b = rq.size();
    int t0 = cyc;
    drive(0, 1, XA, YA);
    in_valid = 0;
    wait_res(b + 1);
    n_tests++;
    if (rq.size() != b + 1) begin n_fail++; $display("FAIL basic_count got %0d want %0d", rq.size() - b, 1); end
    else begin
      n_tests++; if (rq[b].cyc != t0 + 3) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", rq[b].cyc - t0, 3); end
      n_tests++; if (rq[b].p !== PA) begin n_fail++; $display("FAIL basic_p got %h want %h", rq[b].p, PA); end
      n_tests++; if (rq[b].exc !== 6'b0) begin n_fail++; $display("FAIL basic_exc got %b want 0", rq[b].exc); end
      n_tests++; if (rq[b].tag !== 32'd1) begin n_fail++; $display("FAIL basic_tag got %0d want 1", rq[b].tag); end
    end
  endtask

  task automatic test_back_to_back();
    int b = rq.size();
    int t0 = cyc;
    for (int i = 1; i <= 8; i++) drive(!i[0], i, i[0] ? XA : XB, i[0] ? YA : YB);
    in_valid = 0;
    n_tests++; if (cyc != t0 + 8) begin n_fail++; $display("FAIL b2b_accept_cycles got %0d want 8", cyc - t0); end
    wait_res(b + 8);
    n_tests++; if (rq.size() != b + 8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", rq.size() - b); end
    for (int i = 0; i < 8; i++)
      if (b + i < rq.size()) begin
        n_tests++; if (rq[b+i].tag !== 32'(i + 1)) begin n_fail++; $display("FAIL b2b_tag[%0d] got %0d want %0d", i, rq[b+i].tag, i + 1); end
        n_tests++; if (rq[b+i].cyc != t0 + 3 + i) begin n_fail++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", i, rq[b+i].cyc - t0, 3 + i); end
        n_tests++; if (rq[b+i].p !== (i[0] ? PB : PA)) begin n_fail++; $display("FAIL b2b_p[%0d] got %h want %h", i, rq[b+i].p, i[0] ? PB : PA); end
      end
  endtask

  task automatic test_backpressure();
    int b = rq.size();
    int a0 = n_acc;
    out_ready = 0;
    fork
      begin
        for (int i = 11; i <= 15; i++) drive(!i[0], i, i[0] ? XA : XB, i[0] ? YA : YB);
        in_valid = 0;
      end
      begin
        repeat (6) @(posedge clk); #1;
        n_tests++; if (n_acc - a0 != 3) begin n_fail++; $display("FAIL bp_accepted got %0d want 3", n_acc - a0); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        n_tests++; if (out_tag !== 32'd11) begin n_fail++; $display("FAIL bp_stall_tag got %0d want 11", out_tag); end
        n_tests++; if (p !== PA) begin n_fail++; $display("FAIL bp_stall_p got %h want %h", p, PA); end
        repeat (3) @(posedge clk); #1;
        n_tests++; if (n_acc - a0 != 3) begin n_fail++; $display("FAIL bp_accepted_later got %0d want 3", n_acc - a0); end
        n_tests++; if ({out_valid, out_tag, p} !== {1'b1, 32'd11, PA}) begin n_fail++; $display("FAIL bp_hold got v=%b tag=%0d p=%h want 1/11/%h", out_valid, out_tag, p, PA); end
        out_ready = 1;
      end
    join
    wait_res(b + 5);
    repeat (3) @(posedge clk); #1;
    n_tests++; if (rq.size() != b + 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", rq.size() - b); end
    for (int i = 0; i < 5; i++)
      if (b + i < rq.size()) begin
        n_tests++; if (rq[b+i].tag !== 32'(11 + i)) begin n_fail++; $display("FAIL bp_tag[%0d] got %0d want %0d", i, rq[b+i].tag, 11 + i); end
        n_tests++; if (rq[b+i].p !== (i[0] ? PB : PA)) begin n_fail++; $display("FAIL bp_p[%0d] got %h want %h", i, rq[b+i].p, i[0] ? PB : PA); end
      end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      logic [33:0] v;
      int b;
      v = SAT[i]; b = rq.size();
      drive(v[33], 100 + i, {8'h00, v[32:25]}, {16'h0000, v[24:17]});
      in_valid = 0;
      wait_res(b + 1);
      n_tests++;
      if (rq.size() != b + 1) begin n_fail++; $display("FAIL sat_%0d_count got %0d want 1", i, rq.size() - b); end
      else if ({rq[b].p[15:0], rq[b].exc[0]} !== v[16:0]) begin
        n_fail++; $display("FAIL sat_%0d got p=%h exc=%b want p=%h exc=%b", i, rq[b].p[15:0], rq[b].exc[0], v[16:1], v[0]);
      end
    end
  endtask

  task automatic test_specials();
    for (int i = 0; i < 5; i++) begin
      logic [33:0] v;
      int b;
      v = SPC[i]; b = rq.size();
      drive(v[33], 200 + i, {8'h00, v[32:25]}, {16'h0000, v[24:17]});
      in_valid = 0;
      wait_res(b + 1);
      n_tests++;
      if (rq.size() != b + 1) begin n_fail++; $display("FAIL spc_%0d_count got %0d want 1", i, rq.size() - b); end
      else if ({rq[b].p[15:0], rq[b].exc[0]} !== v[16:0]) begin
        n_fail++; $display("FAIL spc_%0d got p=%h exc=%b want p=%h exc=%b", i, rq[b].p[15:0], rq[b].exc[0], v[16:1], v[0]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int b;
    int t0;
    out_ready = 1;
    for (int i = 21; i <= 23; i++) drive(!i[0], i, i[0] ? XA : XB, i[0] ? YA : YB);
    in_valid = 0;
    b = rq.size();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
    #2 rst = 0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid got %b want 0", out_valid); end
    n_tests++; if ({out_tag, p, p_exc} !== '0) begin n_fail++; $display("FAIL mid_async_clear got tag=%0d p=%h exc=%b want 0", out_tag, p, p_exc); end
    @(posedge clk); #1;
    rst = 1;
    repeat (6) @(posedge clk); #1;
    n_tests++; if (rq.size() != b || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale got %0d beats valid=%b want 0/0", rq.size() - b, out_valid); end
    t0 = cyc;
    drive(0, 30, XA, YA);
    in_valid = 0;
    wait_res(b + 1);
    n_tests++;
    if (rq.size() != b + 1) begin n_fail++; $display("FAIL mid_after_count got %0d want 1", rq.size() - b); end
    else if (rq[b].cyc != t0 + 3 || rq[b].tag !== 32'd30 || rq[b].p !== PA) begin
      n_fail++; $display("FAIL mid_after got lat=%0d tag=%0d p=%h want 3/30/%h", rq[b].cyc - t0, rq[b].tag, rq[b].p, PA);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_specials();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog elapsed=200000 want finish earlier");
    $fatal(1, "watchdog");
  end
endmodule
